// File: rtl/mc68030_pds_slave_ctrl.sv
// MC68030 processor-direct-slot slave: decodes the card slot, hands each cycle to a
// backend request/response port and terminates with STERM. Optional bus-error timeout: PDS_BERR_TIMEOUT_EN.
module mc68030_pds_slave_ctrl #(
   parameter logic [3:0]  SLOT_ID = 4'h9,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        cpuclk,
   input  logic        rst,
   input  logic        as_n,
   input  logic        ds_n,
   input  logic        rw_n,
   input  logic [1:0]  siz,
   input  logic [31:0] a,
   input  logic [31:0] d_in,
   output logic [31:0] d_out,
   output logic        d_oe,
   output logic        sterm_n,
   output logic        berr_n,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [23:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT_RSP = 3'd2,
      TERM     = 3'd3,
      RECOVER  = 3'd4
   } state_t;

   // Big-endian lanes: byte offset 0 is D[31:24]; the shift drops lanes past the long-word end.
   function automatic logic [3:0] f_byte_en(input logic [1:0] i_siz, input logic [1:0] i_ofs);
      logic [3:0] v_top;
      case (i_siz)
         2'b01:   v_top = 4'b1000;
         2'b10:   v_top = 4'b1100;
         2'b11:   v_top = 4'b1110;
         default: v_top = 4'b1111;
      endcase
      return v_top >> i_ofs;
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic        r_armed;
   logic        r_req_valid;
   logic        r_req_we;
   logic [23:0] r_req_addr;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_be;
   logic [31:0] r_d_out;
   logic        r_d_oe;
   logic        r_sterm_n;
   logic        w_hit;
   logic        w_miss;
   logic        w_start;
   logic        w_rsp_take;
   logic        w_tmo;
   logic        w_tmo_fire;

   assign w_hit   = (a[31:24] == {4'hF, SLOT_ID});
   assign w_miss  = !as_n && !w_hit;
   assign w_start = (r_state == IDLE) && r_armed && !as_n && !ds_n && w_hit;

`ifdef PDS_BERR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_berr_n;

   assign w_tmo  = ((r_state == REQ) || (r_state == WAIT_RSP)) && (r_tmo_cnt == TW'(TIMEOUT - 1));
   assign berr_n = r_berr_n;

   always_ff @(posedge cpuclk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_berr_n  <= 1'b1;
      end else begin
         if ((r_state != REQ) && (w_next_state == REQ)) begin
            r_tmo_cnt <= '0;
         end else if ((r_state == REQ) || (r_state == WAIT_RSP)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         if (w_tmo_fire) begin
            r_berr_n <= 1'b0;
         end else if (w_next_state == IDLE) begin
            r_berr_n <= 1'b1;
         end
      end
   end
`else
   assign w_tmo  = 1'b0;
   assign berr_n = 1'b1;
`endif

   // Abort beats completion, completion beats timeout.
   always_comb begin
      w_next_state = r_state;
      w_rsp_take   = 1'b0;
      w_tmo_fire   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_next_state = REQ;
            end else begin
               w_next_state = IDLE;
            end
         end
         REQ: begin
            if (as_n) begin
               w_next_state = IDLE;
            end else if (req_ready) begin
               w_next_state = r_req_we ? TERM : WAIT_RSP;
            end else if (w_tmo) begin
               w_tmo_fire   = 1'b1;
               w_next_state = RECOVER;
            end else begin
               w_next_state = REQ;
            end
         end
         WAIT_RSP: begin
            if (as_n) begin
               w_next_state = IDLE;
            end else if (rsp_valid) begin
               w_rsp_take   = 1'b1;
               w_next_state = TERM;
            end else if (w_tmo) begin
               w_tmo_fire   = 1'b1;
               w_next_state = RECOVER;
            end else begin
               w_next_state = WAIT_RSP;
            end
         end
         TERM:    w_next_state = RECOVER;
         RECOVER: begin
            if (as_n) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = RECOVER;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge cpuclk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_armed     <= 1'b0;
         r_req_valid <= 1'b0;
         r_req_we    <= 1'b0;
         r_req_addr  <= 24'h000000;
         r_req_wdata <= 32'h00000000;
         r_req_be    <= 4'b0000;
         r_d_out     <= 32'h00000000;
         r_d_oe      <= 1'b0;
         r_sterm_n   <= 1'b1;
      end else begin
         r_state     <= w_next_state;
         r_req_valid <= (w_next_state == REQ);
         r_sterm_n   <= (w_next_state != TERM);
         // A new cycle needs AS negated first, so a miss or a finished cycle cannot retrigger.
         if (w_start) begin
            r_armed <= 1'b0;
         end else if (as_n && ((r_state == IDLE) || (r_state == RECOVER))) begin
            r_armed <= 1'b1;
         end else if ((r_state == IDLE) && w_miss) begin
            r_armed <= 1'b0;
         end
         if (w_start) begin
            r_req_we    <= ~rw_n;
            r_req_addr  <= a[23:0];
            r_req_wdata <= d_in;
            r_req_be    <= f_byte_en(siz, a[1:0]);
         end
         if (w_rsp_take) begin
            r_d_out <= rsp_rdata;
         end
         if ((w_next_state == TERM) && !r_req_we) begin
            r_d_oe <= 1'b1;
         end else if (w_next_state == IDLE) begin
            r_d_oe <= 1'b0;
         end
      end
   end

   assign req_valid = r_req_valid;
   assign req_we    = r_req_we;
   assign req_addr  = r_req_addr;
   assign req_wdata = r_req_wdata;
   assign req_be    = r_req_be;
   assign d_out     = r_d_out;
   assign d_oe      = r_d_oe;
   assign sterm_n   = r_sterm_n;

endmodule

// File: tb/tb_mc68030_pds_slave_ctrl.sv
// Scoreboard bench for mc68030_pds_slave_ctrl: expected requests are queued at stimulus time
// and compared against requests observed at the accepting edge.
module tb_mc68030_pds_slave_ctrl;
   localparam int TMO = 16;

   logic        cpuclk = 1'b0;
   logic        rst, as_n, ds_n, rw_n, req_ready, rsp_valid;
   logic [1:0]  siz;
   logic [31:0] a, d_in, rsp_rdata;
   logic [31:0] d_out, req_wdata;
   logic        d_oe, sterm_n, berr_n, req_valid, req_we;
   logic [23:0] req_addr;
   logic [3:0]  req_be;

   mc68030_pds_slave_ctrl #(.SLOT_ID(4'h9), .TIMEOUT(TMO)) dut (
      .cpuclk(cpuclk), .rst(rst), .as_n(as_n), .ds_n(ds_n), .rw_n(rw_n), .siz(siz),
      .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .sterm_n(sterm_n), .berr_n(berr_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
   );

   always #5 cpuclk = ~cpuclk;

   typedef struct packed {
      logic        we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t        exp_q[$];
   txn_t        act_q[$];
   int n_pass = 0, n_total = 0;
   int cyc = 0, sterm_cnt = 0, sterm_cyc = -1, berr_cnt = 0, berr_cyc = -1, rv_cnt = 0;

   // Bytes at offsets ofs .. ofs+n-1 (clipped to the long word); offset 0 is be[3].
   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] ofs);
      int n;
      logic [3:0] be;
      n  = (sz == 2'b00) ? 4 : int'(sz);
      be = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if ((k >= int'(ofs)) && (k < int'(ofs) + n)) be[3-k] = 1'b1;
      end
      return be;
   endfunction

   task automatic clr_obs();
      cyc = 0; sterm_cnt = 0; sterm_cyc = -1; berr_cnt = 0; berr_cyc = -1; rv_cnt = 0;
   endtask

   task automatic step();
      if (req_valid && req_ready) act_q.push_back(txn_t'({req_we, req_addr, req_wdata, req_be}));
      @(posedge cpuclk);
      #1;
      cyc++;
      if (req_valid) rv_cnt++;
      if (!sterm_n) begin sterm_cnt++; sterm_cyc = cyc; end
      if (!berr_n) begin if (berr_cnt == 0) berr_cyc = cyc; berr_cnt++; end
   endtask

   task automatic begin_cycle(input logic [31:0] addr, input logic rw, input logic [1:0] sz,
                              input logic [31:0] data, input logic push);
      a = addr; rw_n = rw; siz = sz; d_in = data; as_n = 1'b0; ds_n = 1'b0;
      if (push) exp_q.push_back(txn_t'({~rw, addr[23:0], data, model_be(sz, addr[1:0])}));
      clr_obs();
   endtask

   task automatic end_cycle();
      as_n = 1'b1; ds_n = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
      step(); step();
   endtask

   task automatic test_reset();
      rst = 1'b1; as_n = 1'b1; ds_n = 1'b1; rw_n = 1'b1; siz = 2'b00; a = 32'h0; d_in = 32'h0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
      clr_obs(); step(); step();
      n_total++;
      if ({req_valid, sterm_n, berr_n, d_oe, d_out} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h0})
         $display("FAIL reset: rv/sterm/berr/doe/dout=%b%b%b%b %h required 0110 00000000", req_valid, sterm_n, berr_n, d_oe, d_out);
      else n_pass++;
      rst = 1'b0; step(); step();
   endtask

   task automatic test_write();
      txn_t e, g;
      req_ready = 1'b1;
      begin_cycle(32'hF9000000, 1'b0, 2'b00, 32'h87654321, 1'b1);
      step(); step(); step();
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL write_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL write_sb: got %h required %h", g, e); else n_pass++;
      end
      n_total++;
      if ({g.be, g.addr} !== {4'b1111, 24'h000000}) $display("FAIL write_be_addr: got %b/%h required 1111/000000", g.be, g.addr);
      else n_pass++;
      n_total++;
      if (sterm_cnt !== 1 || sterm_cyc !== 2) $display("FAIL write_sterm: pulses=%0d at cycle %0d required 1 at 2", sterm_cnt, sterm_cyc);
      else n_pass++;
      end_cycle();
   endtask

   task automatic test_read();
      txn_t e, g;
      req_ready = 1'b1; rsp_rdata = 32'hDEADBEEF; rsp_valid = 1'b1;
      begin_cycle(32'hF9000000, 1'b1, 2'b00, 32'h0, 1'b1);
      step(); step();
      rsp_valid = 1'b0; req_ready = 1'b0;
      step(); step();
      rsp_rdata = 32'h87654321; rsp_valid = 1'b1;
      step();
      rsp_valid = 1'b0;
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL read_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL read_sb: got %h required %h", g, e); else n_pass++;
      end
      n_total++;
      if ({d_oe, d_out} !== {1'b1, 32'h87654321} || sterm_cyc !== 5)
         $display("FAIL read_data: doe=%b dout=%h sterm_cyc=%0d required 1 87654321 5", d_oe, d_out, sterm_cyc);
      else n_pass++;
      step();
      n_total++;
      if (d_oe !== 1'b1 || sterm_cnt !== 1) $display("FAIL read_recover: doe=%b pulses=%0d required 1/1", d_oe, sterm_cnt);
      else n_pass++;
      as_n = 1'b1; ds_n = 1'b1;
      step();
      n_total++;
      if (d_oe !== 1'b0) $display("FAIL read_release: doe=%b required 0", d_oe); else n_pass++;
      step();
   endtask

   task automatic test_byte_and_miss();
      txn_t e, g;
      req_ready = 1'b0;
      begin_cycle(32'hF9FFF002, 1'b0, 2'b01, 32'h5A5A5A5A, 1'b1);
      step(); step();
      n_total++;
      if (req_valid !== 1'b1 || txn_t'({req_we, req_addr, req_wdata, req_be}) !== exp_q[0])
         $display("FAIL req_hold: valid=%b payload=%h required 1 %h", req_valid, {req_we, req_addr, req_wdata, req_be}, exp_q[0]);
      else n_pass++;
      req_ready = 1'b1; step();
      req_ready = 1'b0; step();
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL byte_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL byte_sb: got %h required %h", g, e); else n_pass++;
      end
      n_total++;
      if (g.be !== 4'b0010 || sterm_cnt !== 1 || sterm_cyc !== 3)
         $display("FAIL byte_be: be=%b pulses=%0d at %0d required 0010 1 at 3", g.be, sterm_cnt, sterm_cyc);
      else n_pass++;
      end_cycle();
      req_ready = 1'b1;
      begin_cycle(32'hFA000000, 1'b0, 2'b00, 32'h11111111, 1'b0);
      repeat (4) step();
      a = 32'hF9000010;
      repeat (3) step();
      n_total++;
      if (rv_cnt !== 0 || sterm_cnt !== 0 || act_q.size() !== 0)
         $display("FAIL miss_silent: req_valid cycles=%0d sterm=%0d accepts=%0d required 0/0/0", rv_cnt, sterm_cnt, act_q.size());
      else n_pass++;
      end_cycle();
   endtask

   task automatic test_back_to_back();
      txn_t e, g;
      int first_sterm;
      req_ready = 1'b1;
      begin_cycle(32'hF9000003, 1'b0, 2'b10, 32'hA1A1A1A1, 1'b1);
      step(); step(); step();
      first_sterm = sterm_cnt;
      as_n = 1'b1; ds_n = 1'b1;
      step();
      begin_cycle(32'hF9000001, 1'b0, 2'b11, 32'hB2B2B2B2, 1'b1);
      step(); step(); step();
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL b2b_sb%0d: queues exp=%0d act=%0d required >0", i, exp_q.size(), act_q.size());
         else begin
            e = exp_q.pop_front(); g = act_q.pop_front();
            if (g !== e) $display("FAIL b2b_sb%0d: got %h required %h", i, g, e); else n_pass++;
         end
      end
      n_total++;
      if (first_sterm !== 1 || sterm_cnt !== 1 || sterm_cyc !== 2)
         $display("FAIL b2b_sterm: first=%0d second=%0d at %0d required 1 1 at 2", first_sterm, sterm_cnt, sterm_cyc);
      else n_pass++;
      end_cycle();
   endtask

   task automatic test_abort();
      txn_t e, g;
      req_ready = 1'b1;
      begin_cycle(32'hF9000020, 1'b1, 2'b00, 32'h0, 1'b1);
      step(); step();
      req_ready = 1'b0;
      step();
      as_n = 1'b1; ds_n = 1'b1;
      step();
      n_total++;
      if (req_valid !== 1'b0 || d_oe !== 1'b0) $display("FAIL abort_idle: valid=%b doe=%b required 0/0", req_valid, d_oe);
      else n_pass++;
      rsp_rdata = 32'hCAFEF00D; rsp_valid = 1'b1;
      step(); step();
      rsp_valid = 1'b0;
      n_total++;
      if (sterm_cnt !== 0 || d_oe !== 1'b0 || d_out !== 32'h87654321)
         $display("FAIL abort_late_rsp: sterm=%0d doe=%b dout=%h required 0 0 87654321", sterm_cnt, d_oe, d_out);
      else n_pass++;
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL abort_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL abort_sb: got %h required %h", g, e); else n_pass++;
      end
      req_ready = 1'b1;
      begin_cycle(32'hF9000024, 1'b1, 2'b00, 32'h0, 1'b1);
      step(); step();
      req_ready = 1'b0; rsp_rdata = 32'h13579BDF; rsp_valid = 1'b1;
      step();
      rsp_valid = 1'b0;
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL next_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL next_sb: got %h required %h", g, e); else n_pass++;
      end
      n_total++;
      if ({d_oe, d_out} !== {1'b1, 32'h13579BDF} || sterm_cnt !== 1 || sterm_cyc !== 3)
         $display("FAIL next_read: doe=%b dout=%h sterm=%0d at %0d required 1 13579bdf 1 at 3", d_oe, d_out, sterm_cnt, sterm_cyc);
      else n_pass++;
      end_cycle();
   endtask

   task automatic test_timeout();
      txn_t e, g;
      req_ready = 1'b1;
      begin_cycle(32'hF9000040, 1'b1, 2'b00, 32'h0, 1'b1);
      step(); step();
      req_ready = 1'b0;
      repeat (20) step();
`ifdef PDS_BERR_TIMEOUT_EN
      n_total++;
      if (berr_cyc !== TMO + 1 || berr_cnt !== 6 || sterm_cnt !== 0 || req_valid !== 1'b0)
         $display("FAIL tmo_berr: berr at %0d for %0d sterm=%0d valid=%b required %0d for 6 0 0", berr_cyc, berr_cnt, sterm_cnt, req_valid, TMO + 1);
      else n_pass++;
`else
      n_total++;
      if (berr_cnt !== 0 || sterm_cnt !== 0 || req_valid !== 1'b0)
         $display("FAIL tmo_wait: berr cycles=%0d sterm=%0d valid=%b required 0 0 0", berr_cnt, sterm_cnt, req_valid);
      else n_pass++;
`endif
      as_n = 1'b1; ds_n = 1'b1;
      step();
      n_total++;
      if (berr_n !== 1'b1 || d_oe !== 1'b0) $display("FAIL tmo_release: berr_n=%b doe=%b required 1/0", berr_n, d_oe);
      else n_pass++;
      n_total++;
      if (exp_q.size() == 0 || act_q.size() == 0) $display("FAIL tmo_sb: queues exp=%0d act=%0d required 1/1", exp_q.size(), act_q.size());
      else begin
         e = exp_q.pop_front(); g = act_q.pop_front();
         if (g !== e) $display("FAIL tmo_sb: got %h required %h", g, e); else n_pass++;
      end
      end_cycle();
   endtask

   task automatic test_reset_mid();
      req_ready = 1'b0;
      begin_cycle(32'hF9000050, 1'b1, 2'b00, 32'h0, 1'b0);
      step();
      n_total++;
      if (req_valid !== 1'b1) $display("FAIL rstmid_pre: valid=%b required 1", req_valid); else n_pass++;
      rst = 1'b1;
      step();
      n_total++;
      if ({req_valid, sterm_n, berr_n, d_oe, d_out} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h0})
         $display("FAIL rstmid: rv/sterm/berr/doe/dout=%b%b%b%b %h required 0110 00000000", req_valid, sterm_n, berr_n, d_oe, d_out);
      else n_pass++;
      rst = 1'b0; as_n = 1'b1; ds_n = 1'b1;
      step(); step();
      n_total++;
      if (sterm_cnt !== 0 || berr_cnt !== 0 || act_q.size() !== 0 || exp_q.size() !== 0)
         $display("FAIL final_idle: sterm=%0d berr=%0d act=%0d exp=%0d required 0/0/0/0", sterm_cnt, berr_cnt, act_q.size(), exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_byte_and_miss();
      test_back_to_back();
      test_abort();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mc68030_pds_slave_ctrl.md
MC68030_PDS_SLAVE_CTRL -- requirements
Module: mc68030_pds_slave_ctrl

Interface
REQ-001 Parameter SLOT_ID, default 4'h9: card slot; the block decodes A[31:24] == {4'hF, SLOT_ID}.
REQ-002 Parameter TIMEOUT, default 16: cpuclk cycles allowed from request issue to completion.
REQ-003 cpuclk  in  1  sole clock; all logic is on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 as_n, ds_n, rw_n  in  1 each  68030 strobes, already synchronous to cpuclk.
REQ-006 siz  in  2  transfer size: 00=4 bytes, 01=1, 10=2, 11=3.
REQ-007 a  in  32  address; d_in  in  32  write data.
REQ-008 d_out  out  32  read data; d_oe  out  1  data bus drive enable.
REQ-009 sterm_n  out  1  synchronous termination, active low; berr_n  out  1  bus error, active low.
REQ-010 req_valid  out  1; req_ready  in  1; req_we  out  1; req_addr  out  24 (a[23:0]); req_wdata  out  32; req_be  out  4.
REQ-011 rsp_valid  in  1; rsp_rdata  in  32: read completion from the backend.

Function
REQ-012 States: IDLE, REQ, WAIT_RSP, TERM, RECOVER.
REQ-013 IDLE -> REQ when as_n=0, ds_n=0 and the address hits; req_valid=1 on the next cycle, with address, rw, data and byte enables latched in the same cycle.
REQ-014 The block never responds on a miss: outputs stay idle and the state stays IDLE until as_n=1.
REQ-015 req_be: be[3] maps to D[31:24]. Lanes run from a[1:0] for min(size, 4-a[1:0]) bytes. Examples: siz=00,a=0 -> 1111; siz=01,a=2 -> 0010; siz=10,a=3 -> 0001.
REQ-016 REQ: req_valid and all payload are held stable until req_ready=1. The accepting cycle is the one with req_valid & req_ready.
REQ-017 Write: REQ -> TERM on acceptance (posted write). Read: REQ -> WAIT_RSP on acceptance.
REQ-018 WAIT_RSP: on rsp_valid=1, latch rsp_rdata into d_out and go to TERM.
REQ-019 A rsp_valid that coincides with acceptance is ignored; the response is expected from the following cycle.
REQ-020 TERM: sterm_n=0 for exactly one cycle. For reads, d_oe=1 from TERM entry. Next state is RECOVER.
REQ-021 RECOVER: sterm_n=1. d_oe stays at its TERM value. Go to IDLE when as_n=1, where d_oe=0.
REQ-022 as_n=1 while in REQ or WAIT_RSP aborts the cycle. req_valid drops next cycle, the state goes to IDLE, and any pending response is discarded.
REQ-023 rsp_valid outside WAIT_RSP is ignored.
REQ-024 Back-to-back cycles: a new cycle is recognised only after as_n has been seen high in RECOVER or IDLE.

Reset
REQ-025 Reset values: state IDLE, req_valid=0, sterm_n=1, berr_n=1, d_oe=0, d_out=0, timeout counter=0.
REQ-026 Reset asserted mid-cycle takes effect on the next edge regardless of state; the in-flight request is dropped without sterm_n or berr_n.

Configuration
REQ-027 Macro PDS_BERR_TIMEOUT_EN defined: a counter clears on entry to REQ and increments in REQ and WAIT_RSP.
REQ-028 With the macro defined, when the counter reaches TIMEOUT: req_valid=0, berr_n=0, and the state goes to RECOVER. berr_n is held low until as_n=1, then released to 1.
REQ-029 With the macro defined, TERM has priority when completion and timeout coincide.
REQ-030 Macro undefined: no counter, berr_n is constant 1, and REQ and WAIT_RSP wait indefinitely.

Verification
REQ-031 Write 0x87654321 to 0xF9000000 with siz=00, req_ready=1 at once -> req_be=1111, req_addr=0x000000, one sterm_n low pulse two cycles after as_n/ds_n seen.
REQ-032 Read 0xF9000000 with rsp_valid plus 0x87654321 three cycles after acceptance -> d_out=0x87654321, d_oe=1, single sterm_n pulse, d_oe=0 after as_n=1.
REQ-033 Byte write at 0xF9FFF002 with siz=01 -> req_be=0010; access to 0xFA000000 -> no req_valid, no sterm_n.
REQ-034 With PDS_BERR_TIMEOUT_EN, TIMEOUT=16, read with rsp_valid never asserted -> berr_n=0 after 16 cycles, no sterm_n, berr_n=1 after as_n=1.
REQ-035 as_n deasserted while in WAIT_RSP, then a late rsp_valid -> no sterm_n, d_oe=0, IDLE; the next read completes normally.
REQ-036 rst pulsed while in REQ with req_ready=0 -> all outputs at their reset values next cycle.
